alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU (3-bit ALUctr: 0 zero, 1 A+B, 2 A-B, 3 A|B, 4 pass B, 5-7 zero) between two requesters.
  - Port 0: main datapath.
  - Port 1: auxiliary unit, e.g. an address or compare helper.
- Each requester issues an operation through a valid/ready handshake.
- The block round-robin arbitrates, drives the ALU for one cycle and captures the result in a per-requester response register.
- The result is held until that requester acknowledges it.

---
 rtl/alu_share_arbiter_pkg.sv | 17 +
 rtl/alu_rsp_slot.sv | 51 +++++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter.
//   ALU_*       : ALU control codes understood by the external ALU.
//   arb_state_e : arbiter state (IDLE accepts a request, EXEC drives the ALU).
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_ZERO  = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_rsp_slot.sv
// Per-requester response register: holds one ALU result until consumed.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture load_data and raise valid
//   load_data  : result to capture
//   drain      : requester consumes the held result (ignored when empty)
//   valid      : a result is held
//   result     : held result, stable while valid
module alu_rsp_slot
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    // The arbiter never loads a full slot, so load and drain cannot collide.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d  = 1'b1;
            result_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
//   clk, reset            : clock, asynchronous active-low reset
//   req<i>_valid/ready    : operation handshake (a, b, op sampled on handshake)
//   rsp<i>_valid/ready    : result held until the requester consumes it
//   rsp<i>_result         : captured ALU result
//   alu_a, alu_b, alu_ctr : drive the ALU during EXEC, zero otherwise
//   alu_result            : ALU output, captured at the end of EXEC
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned OPW        = 3,
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctr,
    input  logic [WIDTH-1:0] alu_result
);

    // last_q names the previous winner; start it at the other requester so
    // FIRST_PRIO wins the first tie.
    localparam logic LAST_INIT = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] lat_a_q, lat_a_d;
    logic [WIDTH-1:0] lat_b_q, lat_b_d;
    logic [OPW-1:0]   lat_op_q, lat_op_d;
    logic             lat_id_q, lat_id_d;

    logic elig0, elig1, grant_any, grant_id;
    logic load0, load1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        lat_a_d  = lat_a_q;
        lat_b_d  = lat_b_q;
        lat_op_d = lat_op_q;
        lat_id_d = lat_id_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctr  = '0;

        // A slot still holding a result blocks its requester, even if it is
        // being drained this cycle.
        elig0     = req0_valid & ~rsp0_valid;
        elig1     = req1_valid & ~rsp1_valid;
        grant_any = (state_q == IDLE) & (elig0 | elig1);
        grant_id  = (elig0 & elig1) ? ~last_q : elig1;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d  = EXEC;
                    last_d   = grant_id;
                    lat_id_d = grant_id;
                    lat_a_d  = grant_id ? req1_a  : req0_a;
                    lat_b_d  = grant_id ? req1_b  : req0_b;
                    lat_op_d = grant_id ? req1_op : req0_op;
                end
            end
            EXEC: begin
                alu_a   = lat_a_q;
                alu_b   = lat_b_q;
                alu_ctr = lat_op_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        load0 = (state_q == EXEC) & ~lat_id_q;
        load1 = (state_q == EXEC) &  lat_id_q;
    end

    // Reset gates the readies directly so nothing is accepted while it is held.
    assign req0_ready = reset & grant_any & ~grant_id;
    assign req1_ready = reset & grant_any &  grant_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= LAST_INIT;
            lat_a_q  <= '0;
            lat_b_q  <= '0;
            lat_op_q <= '0;
            lat_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            lat_a_q  <= lat_a_d;
            lat_b_q  <= lat_b_d;
            lat_op_q <= lat_op_d;
            lat_id_q <= lat_id_d;
        end
    end

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (load0),
        .load_data (alu_result),
        .drain     (rsp0_ready),
        .valid     (rsp0_valid),
        .result    (rsp0_result)
    );

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (load1),
        .load_data (alu_result),
        .drain     (rsp1_ready),
        .valid     (rsp1_valid),
        .result    (rsp1_result)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .OPW(3), .FIRST_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_result(alu_result)
    );

    // Behavioural ALU: 1 add, 2 sub, 3 or, 4 pass B, everything else zero.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a | b;
            3'd4:    return b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_a, alu_b, alu_ctr);

    task automatic clear_inputs;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 0;
        req0_valid = 1; req0_a = 7; req0_b = 2; req0_op = 1;
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 3;
        @(negedge clk); #1;
        tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready0: got %0h want 0", req0_ready); end
        tests_run++; if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready1: got %0h want 0", req1_ready); end
        tests_run++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %0h/%0h want 0/0", rsp0_valid, rsp1_valid); end
        tests_run++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_result: got %0h/%0h want 0/0", rsp0_result, rsp1_result); end
        tests_run++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctr !== 3'd0) begin tests_failed++; $display("FAIL reset_alu: got %0h/%0h/%0h want 0/0/0", alu_a, alu_b, alu_ctr); end
        @(negedge clk);
        reset = 1;
        #1;
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_first_tie: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_single_op;
        do_reset();
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 1;
        #1;
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL single_ready: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        tests_run++; if (alu_ctr !== 3'd1 || alu_a !== 32'd5 || alu_b !== 32'd3) begin tests_failed++; $display("FAIL single_alu_drive: got %0h/%0h/%0h want 1/5/3", alu_ctr, alu_a, alu_b); end
        tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_rsp_early: got %0h want 0", rsp0_valid); end
        @(negedge clk); #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd8) begin tests_failed++; $display("FAIL single_result: got %0h/%0h want 1/8", rsp0_valid, rsp0_result); end
        tests_run++; if (alu_ctr !== 3'd0 || alu_a !== 32'd0) begin tests_failed++; $display("FAIL single_alu_idle: got %0h/%0h want 0/0", alu_ctr, alu_a); end
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
        #1;
        tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain: got %0h want 0", rsp0_valid); end
    endtask

    task automatic test_tie;
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 1; req0_a = 10;   req0_b = 3;    req0_op = 2;
        req1_valid = 1; req1_a = 'hF0; req1_b = 'h0F; req1_op = 3;
        #1;
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL tie1_grant: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        tests_run++; if (req1_ready !== 1'b0 || alu_ctr !== 3'd2) begin tests_failed++; $display("FAIL tie1_exec: got %0h/%0h want 0/2", req1_ready, alu_ctr); end
        @(negedge clk); #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin tests_failed++; $display("FAIL tie1_rsp0: got %0h/%0h want 1/7", rsp0_valid, rsp0_result); end
        tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL tie1_req1_grant: got %0h want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 0;
        #1;
        tests_run++; if (alu_ctr !== 3'd3 || rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL tie1_exec1: got %0h/%0h want 3/0", alu_ctr, rsp0_valid); end
        @(negedge clk); #1;
        tests_run++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF) begin tests_failed++; $display("FAIL tie1_rsp1: got %0h/%0h want 1/ff", rsp1_valid, rsp1_result); end
        // Last grant went to requester 1, so the next tie goes to 0, then to 1.
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL tie2_grant: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        tests_run++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin tests_failed++; $display("FAIL tie3_grant: got %0h/%0h want 0/1", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        do_reset();
        req1_valid = 1; req1_a = 32'hDEAD; req1_b = 32'h1234; req1_op = 4;
        #1;
        tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_first_accept: got %0h want 1", req1_ready); end
        @(negedge clk);
        req1_a = 2; req1_b = 3; req1_op = 1;
        #1;
        tests_run++; if (req1_ready !== 1'b0 || alu_ctr !== 3'd4) begin tests_failed++; $display("FAIL bp_exec: got %0h/%0h want 0/4", req1_ready, alu_ctr); end
        @(negedge clk);
        req0_valid = 1; req0_a = 7; req0_b = 8; req0_op = 1;
        #1;
        tests_run++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h1234) begin tests_failed++; $display("FAIL bp_rsp1: got %0h/%0h want 1/1234", rsp1_valid, rsp1_result); end
        tests_run++; if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_stall_other_served: got %0h/%0h want 0/1", req1_ready, req0_ready); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        tests_run++; if (req1_ready !== 1'b0 || rsp1_result !== 32'h1234) begin tests_failed++; $display("FAIL bp_hold: got %0h/%0h want 0/1234", req1_ready, rsp1_result); end
        @(negedge clk);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd15) begin tests_failed++; $display("FAIL bp_rsp0: got %0h/%0h want 1/f", rsp0_valid, rsp0_result); end
        tests_run++; if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_drain_same_cycle: got %0h want 0", req1_ready); end
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        tests_run++; if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %0h/%0h want 0/0", rsp0_valid, rsp1_valid); end
        tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_second_accept: got %0h want 1", req1_ready); end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk); #1;
        tests_run++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd5) begin tests_failed++; $display("FAIL bp_second_result: got %0h/%0h want 1/5", rsp1_valid, rsp1_result); end
    endtask

    task automatic test_wrap_undef;
        do_reset();
        req0_valid = 1; req0_a = 0; req0_b = 1; req0_op = 2;
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk); #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL wrap_sub: got %0h/%0h want 1/ffffffff", rsp0_valid, rsp0_result); end
        rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 32'hAAAA; req0_b = 32'h5555; req0_op = 6;
        #1;
        tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL undef_accept: got %0h want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        tests_run++; if (alu_ctr !== 3'd6) begin tests_failed++; $display("FAIL undef_ctr_passthru: got %0h want 6", alu_ctr); end
        @(negedge clk); #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd0) begin tests_failed++; $display("FAIL undef_result: got %0h/%0h want 1/0", rsp0_valid, rsp0_result); end
    endtask

    task automatic test_reset_mid_op;
        do_reset();
        // Move the pointer off its reset value so the post-reset tie proves it was restored.
        req1_valid = 1; req1_op = 1;
        @(negedge clk);
        req1_valid = 0;
        repeat (2) @(negedge clk);
        rsp1_ready = 1;
        @(negedge clk);
        rsp1_ready = 0;
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 1;
        @(negedge clk);
        req0_valid = 0;
        #1;
        tests_run++; if (alu_ctr !== 3'd1) begin tests_failed++; $display("FAIL midrst_exec: got %0h want 1", alu_ctr); end
        reset = 0;
        #1;
        tests_run++; if (rsp0_valid !== 1'b0 || alu_ctr !== 3'd0 || alu_a !== 32'd0) begin tests_failed++; $display("FAIL midrst_abort: got %0h/%0h/%0h want 0/0/0", rsp0_valid, alu_ctr, alu_a); end
        @(negedge clk);
        reset = 1;
        req0_valid = 1; req0_a = 9; req0_b = 4; req0_op = 2;
        req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 1;
        #1;
        tests_run++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_stale: got %0h/%0h want 0/0", rsp0_valid, rsp1_valid); end
        tests_run++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_first_tie: got %0h/%0h want 1/0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); #1;
        tests_run++; if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd5) begin tests_failed++; $display("FAIL midrst_after: got %0h/%0h want 1/5", rsp0_valid, rsp0_result); end
    endtask

    task automatic test_operand_change;
        do_reset();
        req0_valid = 1; req0_a = 100; req0_b = 20; req0_op = 2;
        @(negedge clk);
        req0_valid = 0; req0_a = 999; req0_b = 1; req0_op = 3;
        #1;
        tests_run++; if (alu_a !== 32'd100 || alu_b !== 32'd20 || alu_ctr !== 3'd2) begin tests_failed++; $display("FAIL opchg_latched: got %0h/%0h/%0h want 64/14/2", alu_a, alu_b, alu_ctr); end
        @(negedge clk); #1;
        tests_run++; if (rsp0_result !== 32'd80) begin tests_failed++; $display("FAIL opchg_result: got %0h want 50", rsp0_result); end
    endtask

    // Transaction-level model: an accepted op occupies the ALU for one cycle,
    // then its result sits in the requester's slot until consumed.
    task automatic test_random;
        logic        m_busy, m_id, m_last, g_any, g;
        logic [31:0] m_a, m_b;
        logic [2:0]  m_op;
        logic        m_rv[2];
        logic [31:0] m_rr[2];
        logic        elig[2];
        logic        v[2], rr[2];
        logic [31:0] dut_res[2];
        logic        dut_rv[2];
        do_reset();
        m_busy = 0; m_id = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_rr[0] = 0; m_rr[1] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            req0_b = $urandom; req1_b = $urandom;
            req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
            rsp0_ready = $urandom_range(0, 1); rsp1_ready = $urandom_range(0, 1);
            #1;
            v[0] = req0_valid; v[1] = req1_valid; rr[0] = rsp0_ready; rr[1] = rsp1_ready;
            dut_rv[0] = rsp0_valid; dut_rv[1] = rsp1_valid;
            dut_res[0] = rsp0_result; dut_res[1] = rsp1_result;
            for (int i = 0; i < 2; i++) elig[i] = v[i] && !m_rv[i];
            g_any = !m_busy && (elig[0] || elig[1]);
            g = (elig[0] && elig[1]) ? !m_last : elig[1];
            tests_run++; if (req0_ready !== (g_any && !g) || req1_ready !== (g_any && g)) begin tests_failed++; $display("FAIL rand_ready cyc %0d: got %0h/%0h want %0h/%0h", cyc, req0_ready, req1_ready, g_any && !g, g_any && g); end
            tests_run++; if (alu_ctr !== (m_busy ? m_op : 3'd0) || alu_a !== (m_busy ? m_a : 32'd0) || alu_b !== (m_busy ? m_b : 32'd0)) begin tests_failed++; $display("FAIL rand_alu cyc %0d: got %0h/%0h/%0h", cyc, alu_ctr, alu_a, alu_b); end
            for (int i = 0; i < 2; i++) begin
                tests_run++; if (dut_rv[i] !== m_rv[i]) begin tests_failed++; $display("FAIL rand_rsp_valid%0d cyc %0d: got %0h want %0h", i, cyc, dut_rv[i], m_rv[i]); end
                if (m_rv[i]) begin
                    tests_run++; if (dut_res[i] !== m_rr[i]) begin tests_failed++; $display("FAIL rand_rsp_result%0d cyc %0d: got %0h want %0h", i, cyc, dut_res[i], m_rr[i]); end
                end
            end
            for (int i = 0; i < 2; i++) if (m_rv[i] && rr[i]) m_rv[i] = 0;
            if (m_busy) begin
                m_rv[m_id] = 1;
                m_rr[m_id] = alu_ref(m_a, m_b, m_op);
            end
            if (g_any) begin
                m_busy = 1; m_id = g; m_last = g;
                m_a  = g ? req1_a  : req0_a;
                m_b  = g ? req1_b  : req0_b;
                m_op = g ? req1_op : req0_op;
            end else begin
                m_busy = 0;
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_tie();
        test_backpressure();
        test_wrap_undef();
        test_reset_mid_op();
        test_operand_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
